// File: rtl/multi_phase_clock_generator_if.sv
// Configuration channel of the multi-phase clock generator: a valid/ready
// offer of high/low cycle counts and per-channel phase offsets, plus a reject pulse.
interface multi_phase_clock_generator_if #(
  parameter int CYCLE_WIDTH  = 16,
  parameter int NUM_CHANNELS = 4
);
  logic                                 cfg_valid;
  logic                                 cfg_ready;
  logic [CYCLE_WIDTH-1:0]               high_phase_cycles;
  logic [CYCLE_WIDTH-1:0]               low_phase_cycles;
  logic [NUM_CHANNELS*CYCLE_WIDTH-1:0]  phase_offsets;
  logic                                 cfg_error;

  modport master (
    output cfg_valid,
    output high_phase_cycles,
    output low_phase_cycles,
    output phase_offsets,
    input  cfg_ready,
    input  cfg_error
  );

  modport slave (
    input  cfg_valid,
    input  high_phase_cycles,
    input  low_phase_cycles,
    input  phase_offsets,
    output cfg_ready,
    output cfg_error
  );
endinterface

// File: rtl/multi_phase_clock_generator.sv
// Generates NUM_CHANNELS phase-staggered programmable-duty clocks from one master
// counter; new configurations are staged and swapped in only at a period wrap.
module multi_phase_clock_generator #(
  parameter int CYCLE_WIDTH  = 16,
  parameter int NUM_CHANNELS = 4
) (
  input  logic                      clk_in,
  input  logic                      arst_n,
  input  logic                      enable,
  multi_phase_clock_generator_if.slave cfg,
  output logic [NUM_CHANNELS-1:0]   clk_out,
  output logic                      period_start
);
  localparam int PW = CYCLE_WIDTH + 1;

  logic [CYCLE_WIDTH-1:0]              act_high_reg;
  logic [CYCLE_WIDTH-1:0]              act_low_reg;
  logic [NUM_CHANNELS*CYCLE_WIDTH-1:0] act_offsets_reg;
  logic [CYCLE_WIDTH-1:0]              pend_high_reg;
  logic [CYCLE_WIDTH-1:0]              pend_low_reg;
  logic [NUM_CHANNELS*CYCLE_WIDTH-1:0] pend_offsets_reg;
  logic                                pend_valid_reg;
  logic                                loaded_reg;
  logic                                cfg_error_reg;
  logic                                period_start_reg;
  logic [NUM_CHANNELS-1:0]             clk_out_reg;
  logic [PW-1:0]                       cnt_reg;

  logic [PW-1:0]           act_period;
  logic [PW-1:0]           cfg_period;
  logic [PW-1:0]           last_cnt;
  logic [NUM_CHANNELS-1:0] clk_out_next;
  logic [NUM_CHANNELS-1:0] offset_ok;
  logic                    transfer;
  logic                    cfg_ok;
  logic                    at_wrap;
  logic                    apply;
  logic                    advance;

  assign act_period = {1'b0, act_high_reg} + {1'b0, act_low_reg};
  assign cfg_period = {1'b0, cfg.high_phase_cycles} + {1'b0, cfg.low_phase_cycles};
  assign last_cnt   = act_period - PW'(1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
      logic [PW-1:0] offset_act;
      logic [PW-1:0] pos;

      assign offset_act = {1'b0, act_offsets_reg[gi*CYCLE_WIDTH +: CYCLE_WIDTH]};
      // Position of this channel inside its own shifted period, always in 0..P-1.
      assign pos = (cnt_reg >= offset_act) ? (cnt_reg - offset_act)
                                           : (cnt_reg - offset_act + act_period);
      assign clk_out_next[gi] = (pos < {1'b0, act_high_reg});
      assign offset_ok[gi] =
        ({1'b0, cfg.phase_offsets[gi*CYCLE_WIDTH +: CYCLE_WIDTH]} < cfg_period);
    end
  endgenerate

  assign cfg_ok   = (cfg.high_phase_cycles != '0) && (cfg.low_phase_cycles != '0) && (&offset_ok);
  assign transfer = cfg.cfg_valid && !pend_valid_reg;
  assign at_wrap  = (cnt_reg == last_cnt);
  // The very first configuration goes live immediately; later ones wait for the wrap.
  assign apply    = pend_valid_reg && (!loaded_reg || (enable && at_wrap));
  assign advance  = loaded_reg && enable;

  always_ff @(posedge clk_in or negedge arst_n) begin
    if (!arst_n) begin
      act_high_reg     <= '0;
      act_low_reg      <= '0;
      act_offsets_reg  <= '0;
      pend_high_reg    <= '0;
      pend_low_reg     <= '0;
      pend_offsets_reg <= '0;
      pend_valid_reg   <= 1'b0;
      loaded_reg       <= 1'b0;
      cfg_error_reg    <= 1'b0;
      period_start_reg <= 1'b0;
      clk_out_reg      <= '0;
      cnt_reg          <= '0;
    end else begin
      cfg_error_reg <= transfer && !cfg_ok;

      // Outputs reflect the pre-edge count; while frozen the clocks simply hold.
      if (advance) begin
        clk_out_reg      <= clk_out_next;
        period_start_reg <= (cnt_reg == '0);
      end else begin
        period_start_reg <= 1'b0;
      end

      if (apply) begin
        act_high_reg    <= pend_high_reg;
        act_low_reg     <= pend_low_reg;
        act_offsets_reg <= pend_offsets_reg;
        cnt_reg         <= '0;
        loaded_reg      <= 1'b1;
        pend_valid_reg  <= 1'b0;
      end else begin
        if (advance) begin
          cnt_reg <= at_wrap ? '0 : cnt_reg + PW'(1);
        end
        if (transfer && cfg_ok) begin
          pend_high_reg    <= cfg.high_phase_cycles;
          pend_low_reg     <= cfg.low_phase_cycles;
          pend_offsets_reg <= cfg.phase_offsets;
          pend_valid_reg   <= 1'b1;
        end
      end
    end
  end

  assign clk_out       = clk_out_reg;
  assign period_start  = period_start_reg;
  assign cfg.cfg_ready = !pend_valid_reg;
  assign cfg.cfg_error = cfg_error_reg;

endmodule

// File: tb/tb_multi_phase_clock_generator.sv
// Scoreboard bench: a modulo-arithmetic reference model queues the expected outputs
// per edge, a monitor compares them; directed checks cover the named scenarios.
module tb_multi_phase_clock_generator;
  localparam int CW = 16;
  localparam int N  = 4;

  logic         clk_in = 1'b0;
  logic         arst_n = 1'b0;
  logic         enable = 1'b0;
  logic [N-1:0] clk_out;
  logic         period_start;

  multi_phase_clock_generator_if #(.CYCLE_WIDTH(CW), .NUM_CHANNELS(N)) cfg_bus ();

  multi_phase_clock_generator #(.CYCLE_WIDTH(CW), .NUM_CHANNELS(N)) dut (
    .clk_in       (clk_in),
    .arst_n       (arst_n),
    .enable       (enable),
    .cfg          (cfg_bus),
    .clk_out      (clk_out),
    .period_start (period_start)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [N-1:0] clk;
    logic         ps;
    logic         err;
    logic         rdy;
  } obs_t;

  obs_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model state: active and staged configuration, position within the period.
  int           m_h, m_l, m_cnt, p_h, p_l;
  int           m_o[N];
  int           p_o[N];
  bit           m_pend, m_loaded, m_ps, m_err;
  logic [N-1:0] m_clk;

  always @(posedge clk_in) begin : model
    int   ch, cl, cp;
    bit   xfer, ok, apply;
    obs_t e;
    if (!arst_n) begin
      m_loaded = 0; m_pend = 0; m_cnt = 0; m_h = 0; m_l = 0;
      m_clk = '0; m_ps = 0; m_err = 0;
    end else begin
      ch   = int'(cfg_bus.high_phase_cycles);
      cl   = int'(cfg_bus.low_phase_cycles);
      cp   = ch + cl;
      xfer = cfg_bus.cfg_valid && !m_pend;
      ok   = (ch > 0) && (cl > 0);
      for (int i = 0; i < N; i++)
        if (int'(cfg_bus.phase_offsets[i*CW +: CW]) >= cp) ok = 0;
      if (m_loaded && enable) begin
        for (int i = 0; i < N; i++)
          m_clk[i] = (((m_cnt - m_o[i] + m_h + m_l) % (m_h + m_l)) < m_h);
        m_ps = (m_cnt == 0);
      end else begin
        m_ps = 0;
      end
      apply = m_pend && (!m_loaded || (enable && (m_cnt == m_h + m_l - 1)));
      if (apply) begin
        m_h = p_h; m_l = p_l; m_o = p_o; m_cnt = 0; m_loaded = 1; m_pend = 0;
      end else if (m_loaded && enable) begin
        m_cnt = (m_cnt + 1) % (m_h + m_l);
      end
      m_err = xfer && !ok;
      if (xfer)
        $display("cfg offer t=%0t H=%0d L=%0d -> %s", $time, ch, cl, ok ? "accepted" : "rejected");
      if (xfer && ok) begin
        p_h = ch; p_l = cl;
        for (int i = 0; i < N; i++) p_o[i] = int'(cfg_bus.phase_offsets[i*CW +: CW]);
        m_pend = 1;
      end
    end
    e.clk = m_clk; e.ps = m_ps; e.err = m_err; e.rdy = !m_pend;
    exp_q.push_back(e);
  end

  always @(negedge clk_in) begin : monitor
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {clk_out, period_start, cfg_bus.cfg_error, cfg_bus.cfg_ready};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cycle t=%0t got clk=%b ps=%b err=%b rdy=%b want clk=%b ps=%b err=%b rdy=%b",
                 $time, a.clk, a.ps, a.err, a.rdy, e.clk, e.ps, e.err, e.rdy);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic drive_cfg(input int h, input int l, input logic [N*CW-1:0] offs);
    cfg_bus.high_phase_cycles = CW'(h);
    cfg_bus.low_phase_cycles  = CW'(l);
    cfg_bus.phase_offsets     = offs;
  endtask

  // Called at a falling edge; returns at the falling edge after the transfer edge.
  task automatic offer(input int h, input int l, input logic [N*CW-1:0] offs);
    int n;
    n = 0;
    while (!cfg_bus.cfg_ready && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 100) check("offer_ready_timeout", n, 0);
    drive_cfg(h, l, offs);
    cfg_bus.cfg_valid = 1'b1;
    @(negedge clk_in);
    cfg_bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_ps();
    int n;
    n = 0;
    @(negedge clk_in);
    while (!period_start && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 200) check("period_start_timeout", n, 0);
  endtask

  initial begin : stimulus
    logic [9:0]   pat, pat_exp;
    logic [3:0]   quad_exp [4];
    logic [N*CW-1:0] offs;
    int n, hi, errs, h, l, p;

    quad_exp[0] = 4'b1001; quad_exp[1] = 4'b0011;
    quad_exp[2] = 4'b0110; quad_exp[3] = 4'b1100;
    cfg_bus.cfg_valid = 1'b0;
    drive_cfg(0, 0, '0);

    // Reset, then idle with no configuration.
    repeat (4) @(negedge clk_in);
    check("reset_outputs", int'({clk_out, period_start, cfg_bus.cfg_error}), 0);
    check("reset_ready", int'(cfg_bus.cfg_ready), 1);
    arst_n = 1'b1;
    repeat (50) @(negedge clk_in);
    check("idle_no_cfg", int'(clk_out), 0);

    // Single waveform on channel 0: H=2, L=3.
    enable = 1'b1;
    offer(2, 3, '0);
    repeat (3) @(negedge clk_in);
    wait_ps();
    for (int k = 0; k < 10; k++) begin
      pat[k]     = clk_out[0];
      pat_exp[k] = ((k % 5) < 2);
      @(negedge clk_in);
    end
    check("single_wave", int'(pat), int'(pat_exp));

    // Quadrature: H=2, L=2, offsets 0..3.
    offer(2, 2, {16'd3, 16'd2, 16'd1, 16'd0});
    repeat (12) @(negedge clk_in);
    wait_ps();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("quadrature_%0d", k), int'(clk_out), int'(quad_exp[k]));
      @(negedge clk_in);
    end

    // Reconfiguration at the boundary: 4/4 running, offer 1/1 early in the period.
    offer(4, 4, {16'd6, 16'd4, 16'd2, 16'd0});
    repeat (20) @(negedge clk_in);
    wait_ps();
    drive_cfg(1, 1, '0);
    cfg_bus.cfg_valid = 1'b1;
    @(negedge clk_in);
    cfg_bus.cfg_valid = 1'b0;
    n = 0;
    while (!cfg_bus.cfg_ready && n < 40) begin
      n++;
      @(negedge clk_in);
    end
    check("reconfig_ready_low", n, 6);
    @(negedge clk_in);
    check("reconfig_period_start", int'(period_start), 1);
    check("reconfig_first_high", int'(clk_out[0]), 1);
    @(negedge clk_in);
    check("reconfig_then_low", int'(clk_out[0]), 0);

    // Rejections: offset out of range, then zero high count.
    for (int r = 0; r < 2; r++) begin
      if (r == 0) drive_cfg(2, 3, {16'd0, 16'd0, 16'd0, 16'd5});
      else        drive_cfg(0, 3, '0);
      cfg_bus.cfg_valid = 1'b1;
      @(negedge clk_in);
      cfg_bus.cfg_valid = 1'b0;
      errs = 0;
      for (int k = 0; k < 4; k++) begin
        if (cfg_bus.cfg_error) errs++;
        check($sformatf("reject%0d_ready_%0d", r, k), int'(cfg_bus.cfg_ready), 1);
        @(negedge clk_in);
      end
      check($sformatf("reject%0d_error_pulses", r), errs, 1);
    end

    // Freeze for 3 cycles in the high phase of H=4, L=4.
    offer(4, 4, {16'd6, 16'd4, 16'd2, 16'd0});
    repeat (10) @(negedge clk_in);
    wait_ps();
    enable = 1'b0;
    hi = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_in);
      if (k == 2) enable = 1'b1;
      if (!clk_out[0]) break;
      hi++;
    end
    check("freeze_stretch", hi, 4 + 3);

    // Reset mid-period with a configuration pending.
    repeat (3) @(negedge clk_in);
    offer(3, 3, '0);
    check("pending_before_reset", int'(cfg_bus.cfg_ready), 0);
    @(posedge clk_in);
    #2;
    arst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset_outputs", int'({clk_out, period_start, cfg_bus.cfg_error}), 0);
    check("async_reset_ready", int'(cfg_bus.cfg_ready), 1);
    repeat (3) @(negedge clk_in);
    arst_n = 1'b1;
    repeat (50) @(negedge clk_in);
    check("idle_after_reset", int'(clk_out), 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      enable = ($urandom_range(0, 9) != 0);
      if (cfg_bus.cfg_ready && $urandom_range(0, 19) == 0) begin
        h = $urandom_range(1, 5);
        l = $urandom_range(1, 5);
        p = h + l;
        for (int i = 0; i < N; i++) offs[i*CW +: CW] = CW'($urandom_range(0, p - 1));
        case ($urandom_range(0, 5))
          0:       h = 0;
          1:       offs[$urandom_range(0, N-1)*CW +: CW] = CW'(p + $urandom_range(0, 3));
          2:       l = 0;
          default: ;
        endcase
        drive_cfg(h, l, offs);
        cfg_bus.cfg_valid = 1'b1;
      end else begin
        cfg_bus.cfg_valid = 1'b0;
      end
      @(negedge clk_in);
    end
    cfg_bus.cfg_valid = 1'b0;
    enable = 1'b1;
    repeat (5) @(negedge clk_in);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_phase_clock_generator.md
# multi_phase_clock_generator

Parametrised successor of the single-output custom clock generator: derives `NUM_CHANNELS` programmable-duty clocks from one input clock, all sharing one period but each with its own phase offset in input-clock cycles. Configuration arrives through a valid/ready handshake, is validated, and is applied only at a period boundary, so every channel changes duty and phase together. The block sits between the system clock and the analog/compute tiles that need phase-staggered strobes.

## Interface
- `CYCLE_WIDTH`, 16: width of the high/low cycle counts and of each phase offset.
- `NUM_CHANNELS`, 4: number of output clocks (≥1).

- `clk_in`  input  1: input clock; all logic on its rising edge.
- `arst_n`  input  1: reset, asynchronous and active-low.
- `enable`  input  1: 1 = run the counter; 0 = freeze the counter and all outputs.
- `cfg_valid`  input  1: configuration offered.
- `cfg_ready`  output  1: block can accept a configuration (no pending config).
- `high_phase_cycles`  input  CYCLE_WIDTH: H, input cycles per high phase.
- `low_phase_cycles`  input  CYCLE_WIDTH: L, input cycles per low phase.
- `phase_offsets`  input  NUM_CHANNELS*CYCLE_WIDTH: channel i offset O_i in bits [i*CYCLE_WIDTH +: CYCLE_WIDTH].
- `clk_out`  output  NUM_CHANNELS: generated clocks, registered.
- `period_start`  output  1: one-cycle pulse aligned with the output cycle that reflects cnt == 0.
- `cfg_error`  output  1: one-cycle pulse when an offered configuration is rejected.

## Operation
- P = H + L, computed in CYCLE_WIDTH+1 bits (no overflow).
- State: active config (H, L, O_i), pending config with `pend_valid`, `loaded` flag, master counter `cnt` (CYCLE_WIDTH+1 bits, range 0..P-1).
- Handshake: a transfer occurs on an edge where `cfg_valid && cfg_ready`; `cfg_ready = !pend_valid`.
- Validation at transfer: accept iff H ≠ 0, L ≠ 0 and every O_i < P. On accept: pending ← inputs, `pend_valid` ← 1. On reject: nothing is stored; `cfg_error` = 1 in the next cycle only; `cfg_ready` stays 1.
- Apply pending → active (clears `pend_valid`, sets `cnt` ← 0):
  - If `loaded` = 0: on the first edge after the transfer, regardless of `enable`; this sets `loaded`.
  - If `loaded` = 1: only on an edge where `enable` = 1 and `cnt` = P-1 (the wrap edge).
- Counter: if `loaded` and `enable`, `cnt` ← (cnt = P-1) ? 0 : cnt+1. Otherwise `cnt` holds.
- Channel i position: pos_i = cnt ≥ O_i ? cnt − O_i : cnt − O_i + P.
- Outputs, updated only when `loaded` and `enable`:
  - `clk_out[i]` ← (pos_i < H).
  - `period_start` ← (cnt = 0).
- Outputs while `enable` = 0: `clk_out` holds, and `period_start` is forced to 0.
- Outputs while `loaded` = 0: `clk_out` = 0 and `period_start` = 0.
- Simultaneous transfer and apply cannot occur, because a transfer requires `pend_valid` = 0.
- A phase change at the boundary may shorten one pulse on that channel. This is accepted; duty and phase are exact from the new period onward.
- Reset (`arst_n` low, any time, including mid-period or with a config pending): `clk_out` = 0, `period_start` = 0, `cfg_error` = 0, `cfg_ready` = 1, `cnt` = 0, `loaded` = 0, `pend_valid` = 0, active config cleared. Outputs stay low until a new configuration is loaded.

## Timing
- Output latency: `clk_out`/`period_start` in cycle t+1 reflect `cnt` of cycle t.
- First config: transfer at edge E, active and `cnt` = 0 at edge E+1, `cfg_ready` high again after E+1. If `enable` = 1, outputs for cnt = 0 appear after edge E+2.
- Reconfiguration while running: `cfg_ready` stays low from the transfer until the wrap edge, up to P cycles.
- Steady state: each `clk_out[i]` has period P, high for H cycles, and rises O_i cycles after channel 0 when O_0 = 0.
- `enable` deasserted for k cycles stretches the current phase by exactly k cycles on every channel.
- `cfg_error` is asserted exactly one cycle after the rejecting edge.

## Test plan
- Reset: hold `arst_n` = 0 → all outputs 0 and `cfg_ready` = 1. Release with no config → outputs stay 0 for 50 cycles.
- Single waveform: NUM_CHANNELS = 1, H = 2, L = 3, O = 0, `enable` = 1 → `clk_out` repeats 1,1,0,0,0; `period_start` is high on the first 1 of each period.
- Quadrature: NUM_CHANNELS = 4, H = 2, L = 2, O = {0,1,2,3} → the four channels are 1-cycle-staggered copies of 1,1,0,0, with channel 3 high when cnt ∈ {3,0}.
- Reconfig at boundary: running H = 4, L = 4; offer H = 1, L = 1 at cnt = 2 → `cfg_ready` low for 6 cycles; the new 1,0 pattern starts exactly at the next `period_start`; no change mid-period.
- Rejection: offer H = 2, L = 3, O_0 = 5 (and separately H = 0) → `cfg_error` pulses once, the active config is unchanged, `cfg_ready` stays 1.
- Freeze and reset: drop `enable` for 3 cycles mid-high phase → high phase lasts H + 3. Assert `arst_n` mid-period with a config pending → immediate 0 outputs, `cfg_ready` = 1, pending config discarded.
